// File: rtl/dmem_store_buffer_pkg.sv
// Shared defines and helpers for the data-memory store buffer.
// Optional feature macro: STORE_FWD_EN (load forwarding from the youngest
// full-word buffered store). Default build has forwarding disabled.

`ifndef CPU_DATA_BITS
`define CPU_DATA_BITS 32
`endif

`ifndef SB_WE_BITS
`define SB_WE_BITS 4
`endif

`ifndef SB_WE_FULL
`define SB_WE_FULL 4'b1111
`endif

package dmem_store_buffer_pkg;

    localparam int unsigned DATA_BITS = `CPU_DATA_BITS;
    localparam int unsigned WE_BITS   = `SB_WE_BITS;
    localparam logic [WE_BITS-1:0] WE_FULL = `SB_WE_FULL;

    // True when a store writes at least one byte lane.
    function automatic logic we_is_any(input logic [WE_BITS-1:0] we);
        return (we != {WE_BITS{1'b0}});
    endfunction

    // True when a store covers the whole word, making it forwardable.
    function automatic logic we_is_full(input logic [WE_BITS-1:0] we);
        return (we == WE_FULL);
    endfunction

endpackage

// File: rtl/dmem_sb_match.sv
// Load-vs-buffer word-address compare. Scans entries from oldest to youngest
// relative to the tail pointer so that the youngest matching entry wins.

module dmem_sb_match #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WORD_BITS = 30,
    localparam int unsigned PTR_BITS = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]     ent_valid,
    input  logic [WORD_BITS-1:0] ent_addr [DEPTH],
    input  logic [WORD_BITS-1:0] ld_word,
    input  logic [PTR_BITS-1:0]  tail_ptr,
    output logic                 hit,
    output logic [PTR_BITS-1:0]  hit_idx
);

    logic [PTR_BITS-1:0] cand_s;

    // Youngest-first priority select: later (younger) matches overwrite older ones.
    always_comb begin
        hit     = 1'b0;
        hit_idx = {PTR_BITS{1'b0}};
        cand_s  = {PTR_BITS{1'b0}};
        for (int k = DEPTH; k >= 1; k--) begin
            cand_s = tail_ptr - PTR_BITS'(k);
            if (ent_valid[cand_s] && (ent_addr[cand_s] == ld_word)) begin
                hit     = 1'b1;
                hit_idx = cand_s;
            end else begin
                hit     = hit;
                hit_idx = hit_idx;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the EX store-lane formatter and the data cache.
// Committed stores queue in a circular FIFO and drain in program order.
// Loads hitting a buffered word stall; with STORE_FWD_EN defined, a hit on a
// youngest full-word entry forwards its data instead.

module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      st_valid,
    input  logic [ADDR_BITS-1:0]      st_addr,
    input  logic [`CPU_DATA_BITS-1:0] st_data,
    input  logic [3:0]                st_we,
    output logic                      st_ready,
    output logic                      mem_req_valid,
    output logic [ADDR_BITS-1:0]      mem_addr,
    output logic [`CPU_DATA_BITS-1:0] mem_data,
    output logic [3:0]                mem_we,
    input  logic                      mem_req_ready,
    input  logic                      ld_valid,
    input  logic [ADDR_BITS-1:0]      ld_addr,
    output logic                      ld_stall,
    output logic                      ld_fwd_valid,
    output logic [`CPU_DATA_BITS-1:0] ld_fwd_data,
    output logic                      sb_empty
);

    localparam int unsigned PTR_BITS  = $clog2(DEPTH);
    localparam int unsigned CNT_BITS  = PTR_BITS + 1;
    localparam int unsigned WORD_BITS = ADDR_BITS - 2;
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(DEPTH);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);

    logic [WORD_BITS-1:0]      addr_q [DEPTH];
    logic [WORD_BITS-1:0]      addr_d [DEPTH];
    logic [DATA_BITS-1:0]      data_q [DEPTH];
    logic [DATA_BITS-1:0]      data_d [DEPTH];
    logic [WE_BITS-1:0]        we_q   [DEPTH];
    logic [WE_BITS-1:0]        we_d   [DEPTH];
    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [PTR_BITS-1:0]       head_q, head_d;
    logic [PTR_BITS-1:0]       tail_q, tail_d;
    logic [CNT_BITS-1:0]       count_q, count_d;

    logic                      push_s;
    logic                      pop_s;
    logic                      hit_s;
    logic [PTR_BITS-1:0]       hit_idx_s;
    logic                      unused_bits_s;

    // Flow control depends only on registered occupancy, never on mem_req_ready.
    assign st_ready      = (count_q != CNT_FULL);
    assign mem_req_valid = (count_q != {CNT_BITS{1'b0}});
    assign sb_empty      = (count_q == {CNT_BITS{1'b0}});
    assign push_s        = st_valid & st_ready & we_is_any(st_we);
    assign pop_s         = mem_req_valid & mem_req_ready;

    assign mem_addr = {addr_q[head_q], 2'b00};
    assign mem_data = data_q[head_q];
    assign mem_we   = we_q[head_q];

    // Byte-offset bits are irrelevant to word-granular buffering.
    assign unused_bits_s = ^{st_addr[1:0], ld_addr[1:0]};

    // Next-state for FIFO storage, pointers and occupancy.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push_s) begin
            addr_d[tail_q]  = st_addr[ADDR_BITS-1:2];
            data_d[tail_q]  = st_data;
            we_d[tail_q]    = st_we;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the buffer and abandons any pending drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= {WORD_BITS{1'b0}};
                data_q[i] <= {DATA_BITS{1'b0}};
                we_q[i]   <= {WE_BITS{1'b0}};
            end
            valid_q <= {DEPTH{1'b0}};
            head_q  <= {PTR_BITS{1'b0}};
            tail_q  <= {PTR_BITS{1'b0}};
            count_q <= {CNT_BITS{1'b0}};
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    dmem_sb_match #(
        .DEPTH     (DEPTH),
        .WORD_BITS (WORD_BITS)
    ) u_match (
        .ent_valid (valid_q),
        .ent_addr  (addr_q),
        .ld_word   (ld_addr[ADDR_BITS-1:2]),
        .tail_ptr  (tail_q),
        .hit       (hit_s),
        .hit_idx   (hit_idx_s)
    );

`ifdef STORE_FWD_EN
    // Forward from the youngest hit if it covers the full word, otherwise stall.
    always_comb begin
        ld_stall     = 1'b0;
        ld_fwd_valid = 1'b0;
        ld_fwd_data  = {DATA_BITS{1'b0}};
        if (ld_valid && hit_s) begin
            if (we_is_full(we_q[hit_idx_s])) begin
                ld_fwd_valid = 1'b1;
                ld_fwd_data  = data_q[hit_idx_s];
            end else begin
                ld_stall = 1'b1;
            end
        end else begin
            ld_stall = 1'b0;
        end
    end
`else
    logic [PTR_BITS-1:0] unused_idx_s;
    assign unused_idx_s = hit_idx_s;
    assign ld_stall     = ld_valid & hit_s;
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = {DATA_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer (DEPTH=4, ADDR_BITS=32).
// Forwarding checks are compiled in only when STORE_FWD_EN is defined.

`ifndef CPU_DATA_BITS
`define CPU_DATA_BITS 32
`endif

module tb_dmem_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [`CPU_DATA_BITS-1:0] st_data;
    logic [3:0]  st_we;
    logic        st_ready;
    logic        mem_req_valid;
    logic [31:0] mem_addr;
    logic [`CPU_DATA_BITS-1:0] mem_data;
    logic [3:0]  mem_we;
    logic        mem_req_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        ld_fwd_valid;
    logic [`CPU_DATA_BITS-1:0] ld_fwd_data;
    logic        sb_empty;

    int err_cnt;
    int chk_cnt;

    dmem_store_buffer #(
        .DEPTH     (4),
        .ADDR_BITS (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid      (st_valid),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_we         (st_we),
        .st_ready      (st_ready),
        .mem_req_valid (mem_req_valid),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_we        (mem_we),
        .mem_req_ready (mem_req_ready),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_stall      (ld_stall),
        .ld_fwd_valid  (ld_fwd_valid),
        .ld_fwd_data   (ld_fwd_data),
        .sb_empty      (sb_empty)
    );

    // Free-running core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_we    = w;
        step();
        st_valid = 1'b0;
    endtask

    // Directed stimulus sequence.
    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst = 1'b1;
        st_valid = 1'b0;
        st_addr = 32'h0;
        st_data = 32'h0;
        st_we = 4'b0000;
        mem_req_ready = 1'b0;
        ld_valid = 1'b0;
        ld_addr = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check_eq("rst_st_ready", 64'(st_ready), 64'd1);
        check_eq("rst_sb_empty", 64'(sb_empty), 64'd1);
        check_eq("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check_eq("rst_ld_stall", 64'(ld_stall), 64'd0);
        check_eq("rst_fwd_valid", 64'(ld_fwd_valid), 64'd0);

        // Fill the buffer with the dcache stalled.
        for (int i = 0; i < 4; i++) begin
            check_eq("fill_st_ready", 64'(st_ready), 64'd1);
            put_store(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111);
        end
        check_eq("full_st_ready", 64'(st_ready), 64'd0);
        check_eq("full_mem_valid", 64'(mem_req_valid), 64'd1);
        put_store(32'h110, 32'hDEAD_BEEF, 4'b1111);
        check_eq("full_mem_addr", 64'(mem_addr), 64'h100);
        check_eq("full_mem_data", 64'(mem_data), 64'hA000_0000);

        // Drain in order; the rejected fifth store must not appear.
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_addr", 64'(mem_addr), 64'(32'h100 + 32'(4 * i)));
            check_eq("drain_data", 64'(mem_data), 64'(32'hA000_0000 + 32'(i)));
            check_eq("drain_we", 64'(mem_we), 64'hF);
            step();
        end
        mem_req_ready = 1'b0;
        check_eq("drain_sb_empty", 64'(sb_empty), 64'd1);
        check_eq("drain_mem_valid", 64'(mem_req_valid), 64'd0);

        // Partial-mask store hit stalls the load until drained.
        put_store(32'h200, 32'h0000_AB00, 4'b0010);
        check_eq("part_mem_addr", 64'(mem_addr), 64'h200);
        check_eq("part_mem_we", 64'(mem_we), 64'h2);
        check_eq("part_mem_data", 64'(mem_data), 64'h0000_AB00);
        ld_valid = 1'b1;
        ld_addr = 32'h201;
        #1;
        check_eq("part_ld_stall", 64'(ld_stall), 64'd1);
        check_eq("part_fwd_valid", 64'(ld_fwd_valid), 64'd0);
        step();
        check_eq("part_stall_hold", 64'(ld_stall), 64'd1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check_eq("part_stall_clear", 64'(ld_stall), 64'd0);
        check_eq("part_sb_empty", 64'(sb_empty), 64'd1);
        ld_valid = 1'b0;

        // Same-cycle store is not compared, and reaches mem_* one cycle later.
        st_valid = 1'b1;
        st_addr = 32'h400;
        st_data = 32'h4444_0000;
        st_we = 4'b1111;
        ld_valid = 1'b1;
        ld_addr = 32'h400;
        #1;
        check_eq("same_cyc_stall", 64'(ld_stall), 64'd0);
        check_eq("same_cyc_mem_valid", 64'(mem_req_valid), 64'd0);
        step();
        st_valid = 1'b0;
        check_eq("lat_mem_valid", 64'(mem_req_valid), 64'd1);
        check_eq("lat_mem_addr", 64'(mem_addr), 64'h400);
        check_eq("lat_ld_stall", 64'(ld_stall), 64'd1);
        // Simultaneous push and pop keeps occupancy at one.
        mem_req_ready = 1'b1;
        put_store(32'h404, 32'h4444_0004, 4'b1111);
        mem_req_ready = 1'b0;
        check_eq("sim_mem_addr", 64'(mem_addr), 64'h404);
        check_eq("sim_sb_empty", 64'(sb_empty), 64'd0);
        check_eq("sim_ld_stall", 64'(ld_stall), 64'd0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check_eq("sim_drained", 64'(sb_empty), 64'd1);
        ld_valid = 1'b0;

`ifdef STORE_FWD_EN
        // Youngest full-word hit forwards its data.
        put_store(32'h300, 32'h1111_1111, 4'b1111);
        put_store(32'h300, 32'h2222_2222, 4'b1111);
        ld_valid = 1'b1;
        ld_addr = 32'h300;
        #1;
        check_eq("fwd_valid", 64'(ld_fwd_valid), 64'd1);
        check_eq("fwd_data", 64'(ld_fwd_data), 64'h2222_2222);
        check_eq("fwd_stall", 64'(ld_stall), 64'd0);
        ld_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready = 1'b0;
        check_eq("fwd_drained", 64'(sb_empty), 64'd1);
`endif

        // Reset with entries queued discards them.
        for (int i = 0; i < 3; i++) begin
            put_store(32'h500 + 32'(4 * i), 32'h5500_0000 + 32'(i), 4'b1111);
        end
        check_eq("pre_rst_valid", 64'(mem_req_valid), 64'd1);
        rst = 1'b1;
        step();
        check_eq("mid_rst_sb_empty", 64'(sb_empty), 64'd1);
        check_eq("mid_rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check_eq("mid_rst_st_ready", 64'(st_ready), 64'd1);
        rst = 1'b0;
        step();
        put_store(32'h600, 32'h6666_6666, 4'b0000);
        check_eq("we0_sb_empty", 64'(sb_empty), 64'd1);
        check_eq("we0_mem_valid", 64'(mem_req_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Sits directly downstream of the EX-stage store-lane formatter, which produces the byte-lane-aligned write data and the 4-bit byte-enable mask.
- Buffers committed stores in a FIFO and drains them to the data cache over a valid/ready port, so a busy dcache does not stall EX.
- Detects loads whose word address hits a buffered store; optionally forwards data from the youngest full-word hit.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.
- ADDR_BITS, 32, byte-address width.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- st_valid  input  1  store from EX is valid this cycle.
- st_addr  input  ADDR_BITS  store byte address; only [ADDR_BITS-1:2] is stored.
- st_data  input  `CPU_DATA_BITS  lane-aligned store data.
- st_we  input  4  byte-enable mask.
- st_ready  output  1  buffer can accept a store.
- mem_req_valid  output  1  head entry presented to dcache.
- mem_addr  output  ADDR_BITS  head word address, with [1:0]=2'b00.
- mem_data  output  `CPU_DATA_BITS  head data.
- mem_we  output  4  head byte-enable mask.
- mem_req_ready  input  1  dcache accepts the head entry.
- ld_valid  input  1  load in EX.
- ld_addr  input  ADDR_BITS  load byte address.
- ld_stall  output  1  load must hold in EX.
- ld_fwd_valid  output  1  forwarded data valid (tied 0 without STORE_FWD_EN).
- ld_fwd_data  output  `CPU_DATA_BITS  forwarded word (tied 0 without STORE_FWD_EN).
- sb_empty  output  1  no buffered stores; used by fence/drain logic.

Behaviour:
- Reset, asynchronous on rst high:
  - head/tail pointers and count cleared; all entry valid bits cleared.
  - Outputs after reset: mem_req_valid=0, st_ready=1, sb_empty=1, ld_stall=0, ld_fwd_valid=0.
  - Assertion mid-drain discards all entries; a pending mem handshake is abandoned.
- Storage:
  - Circular FIFO of DEPTH entries {addr[ADDR_BITS-1:2], data, we}.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Enqueue:
  - Occurs on st_valid & st_ready & (st_we != 0).
  - st_valid with st_we==0 is accepted and dropped; nothing is enqueued.
  - st_ready = (count != DEPTH). It is registered-state only and does not depend on mem_req_ready, so there is no combinational path from the dcache.
- Dequeue:
  - mem_req_valid = (count != 0); mem_* are driven from the head entry.
  - Pop occurs on mem_req_valid & mem_req_ready.
  - mem_* hold stable while mem_req_valid=1 and mem_req_ready=0.
- Simultaneous enqueue and pop: count is unchanged, both pointers advance.
  - When full, a same-cycle pop does not permit an enqueue, because st_ready is 0.
  - When empty, a same-cycle enqueue is not visible on mem_* until the next cycle, so minimum store-to-dcache latency is 1 cycle.
- Load check:
  - Compare ld_addr[ADDR_BITS-1:2] against every valid entry.
  - Only buffered entries are compared; the same-cycle st_* input is excluded.
  - hit = ld_valid & any match. Without forwarding, ld_stall = hit.
  - The stall persists until all matching entries have drained.
- Ordering: stores drain strictly in program order. Byte masks are passed through unmodified.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined:
  - On hit, select the youngest matching entry (nearest to tail).
  - If its we==4'b1111: ld_fwd_valid=1, ld_fwd_data = entry data, ld_stall=0.
  - Otherwise ld_stall=1 and ld_fwd_valid=0.
  - A load with no hit has ld_fwd_valid=0.
- Undefined: ld_fwd_valid and ld_fwd_data are tied 0; any hit stalls.

Decomposition:
- const.vh: `CPU_DATA_BITS, plus new `SB_WE_BITS (4) and `SB_WE_FULL (4'b1111).
- No new package beyond these defines.
- One natural sub-module: dmem_sb_match.
  - Combinational DEPTH-way word-address compare with youngest-first priority select, relative to tail.
  - Outputs a hit flag and the selected index.

Test Plan:
- Reset then idle -> st_ready=1, sb_empty=1, mem_req_valid=0.
- Enqueue 4 stores (addr 0x100,0x104,0x108,0x10C, we=1111) with mem_req_ready=0 -> st_ready=0 after the 4th store; a 5th st_valid is not accepted; mem_addr stays 0x100.
- Full buffer, mem_req_ready=1 for 4 cycles -> mem_addr sequence 0x100,0x104,0x108,0x10C in order, then sb_empty=1.
- Store 0x200 with we=0010 and data 0x0000AB00, then load 0x201 -> ld_stall=1 until the dcache accepts 0x200, then ld_stall=0.
  - With STORE_FWD_EN the result is the same, since the mask is partial.
- STORE_FWD_EN: stores to 0x300 with data 0x11111111 then data 0x22222222 (we=1111), then load 0x300 -> ld_fwd_valid=1, ld_fwd_data=0x22222222, ld_stall=0.
- Assert rst with 3 entries queued and mem_req_ready=0 -> on the next clock sb_empty=1 and mem_req_valid=0; a store with st_we=0 afterwards leaves sb_empty=1.
